// File: rtl/multiplier_sequencer.sv
// Sequential signed shift-add multiplier (Booth-style final subtract).
// Owns the A/B/X registers and issues the Add, Sub and Clr_Ld strobes,
// consuming one multiplier bit per ADD/SHF pair.
module multiplier_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Add,
  output logic             Sub,
  output logic             Clr_Ld,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] BIT_ONE  = CW'(1);
  localparam logic [CW-1:0] BIT_ZERO = CW'(0);
  localparam logic [WIDTH:0] SUM_ONE = (WIDTH + 1)'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_ADD  = 3'd2,
    ST_SHF  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CW-1:0]     r_bit;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_x;

  logic              w_add;
  logic              w_sub;
  logic              w_clr;
  logic              w_done;
  logic [WIDTH:0]    w_s_ext;
  logic [WIDTH:0]    w_operand;
  logic [WIDTH:0]    w_sum;

  // State register and bit counter (counter advances after every shift).
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_bit   <= BIT_ZERO;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_CLR) begin
        r_bit <= BIT_ZERO;
      end else if (r_state == ST_SHF) begin
        r_bit <= r_bit + BIT_ONE;
      end else begin
        r_bit <= r_bit;
      end
    end
  end

  // Next-state logic: CLR, then ADD/SHF pairs per bit, then DONE until Run drops.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (Run) begin
          w_next_state = ST_CLR;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CLR:  w_next_state = ST_ADD;
      ST_ADD:  w_next_state = ST_SHF;
      ST_SHF: begin
        if (r_bit == LAST_BIT) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_ADD;
        end
      end
      ST_DONE: begin
        if (!Run) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_DONE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Strobe decode from registered state only; the sign bit of B selects Sub on the last bit.
  always_comb begin
    w_add  = 1'b0;
    w_sub  = 1'b0;
    w_clr  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_CLR:  w_clr = 1'b1;
      ST_ADD: begin
        if (r_b[0] && (r_bit == LAST_BIT)) begin
          w_sub = 1'b1;
        end else if (r_b[0]) begin
          w_add = 1'b1;
        end else begin
          w_add = 1'b0;
        end
      end
      ST_DONE: w_done = 1'b1;
      default: w_done = 1'b0;
    endcase
  end

  // Sign-extended sum of A and +/-S; the carry out of the top bit is dropped.
  always_comb begin
    w_s_ext = {SW[WIDTH-1], SW};
    if (w_sub) begin
      w_operand = ~w_s_ext + SUM_ONE;
    end else begin
      w_operand = w_s_ext;
    end
    w_sum = {r_a[WIDTH-1], r_a} + w_operand;
  end

  // A/B/X datapath: load/clear in IDLE, clear in CLR, accumulate, arithmetic shift.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_a <= '0;
      r_b <= '0;
      r_x <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ClearA_LoadB) begin
            r_a <= '0;
            r_x <= 1'b0;
            r_b <= SW;
          end else begin
            r_a <= r_a;
            r_x <= r_x;
            r_b <= r_b;
          end
        end
        ST_CLR: begin
          r_a <= '0;
          r_x <= 1'b0;
        end
        ST_ADD: begin
          if (w_add || w_sub) begin
            {r_x, r_a} <= w_sum;
          end else begin
            r_a <= r_a;
            r_x <= r_x;
          end
        end
        ST_SHF: begin
          r_a <= {r_x, r_a[WIDTH-1:1]};
          r_b <= {r_a[0], r_b[WIDTH-1:1]};
        end
        default: begin
          r_a <= r_a;
          r_b <= r_b;
          r_x <= r_x;
        end
      endcase
    end
  end

  assign Aval   = r_a;
  assign Bval   = r_b;
  assign X      = r_x;
  assign Add    = w_add;
  assign Sub    = w_sub;
  assign Clr_Ld = w_clr;
  assign Done   = w_done;

endmodule

// File: tb/tb_multiplier_sequencer.sv
// Self-checking bench for multiplier_sequencer: scoreboard of expected
// products/strobe counts pushed at run start and popped when Done rises.
module tb_multiplier_sequencer;

  logic       Clk;
  logic       Reset;
  logic       Run;
  logic       ClearA_LoadB;
  logic [7:0] SW;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       X;
  logic       Add;
  logic       Sub;
  logic       Clr_Ld;
  logic       Done;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       x;
    logic [3:0] adds;
    logic       subs;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks;
  int         n_fails;
  int         add_total;
  int         sub_total;
  int         clr_total;
  int         multi_hot;
  logic [7:0] mb;

  multiplier_sequencer #(.WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .SW(SW),
    .Aval(Aval), .Bval(Bval), .X(X), .Add(Add), .Sub(Sub), .Clr_Ld(Clr_Ld), .Done(Done)
  );

  // 10 ns clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Strobe monitor: cumulative counts and one-hot violations, sampled mid-cycle.
  always @(negedge Clk) begin
    if (Add) add_total++;
    if (Sub) sub_total++;
    if (Clr_Ld) clr_total++;
    if ((int'(Add) + int'(Sub) + int'(Clr_Ld)) > 1) multi_hot++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic load_b(input logic [7:0] v);
    SW = v;
    ClearA_LoadB = 1'b1;
    @(negedge Clk);
    ClearA_LoadB = 1'b0;
    check_val("load_B", Bval, v);
    check_val("load_A", Aval, 8'h00);
    check_val("load_X", X, 1'b0);
    mb = v;
  endtask

  // Runs one multiply. abort_cyc>0 asserts reset at that cycle; pulse_cyc>0
  // pulses ClearA_LoadB at that cycle; hold_cyc keeps Run high in DONE.
  task automatic do_run(input logic [7:0] s, input logic also_load,
                        input int abort_cyc, input int pulse_cyc, input int hold_cyc);
    logic [7:0]        mult;
    logic signed [15:0] p;
    exp_t              e;
    exp_t              got;
    int                cyc;
    bit                aborted;
    int                a0, s0, c0;
    mult = also_load ? s : mb;
    p = $signed(mult) * $signed(s);
    e.a = p[15:8];
    e.b = p[7:0];
    e.x = p[15];
    e.adds = 4'($countones(mult[6:0]));
    e.subs = mult[7];
    exp_q.push_back(e);
    a0 = add_total; s0 = sub_total; c0 = clr_total;
    SW = s;
    ClearA_LoadB = also_load;
    Run = 1'b1;
    cyc = 0;
    aborted = 1'b0;
    do begin
      @(negedge Clk);
      cyc++;
      if (cyc == 1) begin
        ClearA_LoadB = 1'b0;
        check_val("clr_first", Clr_Ld, 1'b1);
      end
      if (pulse_cyc > 0 && cyc == pulse_cyc) ClearA_LoadB = 1'b1;
      if (pulse_cyc > 0 && cyc == pulse_cyc + 1) ClearA_LoadB = 1'b0;
      if (abort_cyc > 0 && cyc == abort_cyc) begin
        check_val("pre_abort_state_add", Clr_Ld, 1'b0);
        Reset = 1'b0;
        Run = 1'b0;
        #1;
        check_val("abort_A", Aval, 8'h00);
        check_val("abort_B", Bval, 8'h00);
        check_val("abort_X", X, 1'b0);
        check_val("abort_Done", Done, 1'b0);
        check_val("abort_strobes", {Add, Sub, Clr_Ld}, 3'b000);
        aborted = 1'b1;
      end
    end while (!Done && cyc < 40 && !aborted);

    if (aborted) begin
      void'(exp_q.pop_front());
      mb = 8'h00;
      @(negedge Clk);
      Reset = 1'b1;
      repeat (3) begin
        @(negedge Clk);
        check_val("idle_after_reset", {Done, Add, Sub, Clr_Ld}, 4'b0000);
      end
      check_val("idle_after_reset_B", Bval, 8'h00);
    end else begin
      check_val("latency", cyc, 18);
      got = exp_q.pop_front();
      check_val("prod_A", Aval, got.a);
      check_val("prod_B", Bval, got.b);
      check_val("prod_X", X, got.x);
      check_val("add_count", add_total - a0, got.adds);
      check_val("sub_count", sub_total - s0, got.subs);
      check_val("clr_count", clr_total - c0, 1);
      for (int i = 0; i < hold_cyc; i++) begin
        @(negedge Clk);
        check_val("hold_Done", Done, 1'b1);
      end
      if (hold_cyc > 0) begin
        check_val("hold_A", Aval, got.a);
        check_val("hold_B", Bval, got.b);
        check_val("hold_clr", clr_total - c0, 1);
      end
      Run = 1'b0;
      @(negedge Clk);
      check_val("exit_Done", Done, 1'b0);
      mb = got.b;
    end
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    add_total = 0; sub_total = 0; clr_total = 0; multi_hot = 0;
    mb = 8'h00;
    Reset = 1'b0; Run = 1'b0; ClearA_LoadB = 1'b0; SW = 8'h00;
    repeat (2) @(negedge Clk);
    check_val("rst_A", Aval, 8'h00);
    check_val("rst_B", Bval, 8'h00);
    check_val("rst_X", X, 1'b0);
    check_val("rst_outs", {Done, Add, Sub, Clr_Ld}, 4'b0000);
    Reset = 1'b1;
    @(negedge Clk);

    // Reset in ADD_3 (cycle 8 after Run is sampled).
    load_b(8'h55);
    do_run(8'h33, 1'b0, 8, 0, 0);

    // 7 x -3 = -21
    load_b(8'h07);
    do_run(8'hFD, 1'b0, 0, 0, 0);

    // -128 x -128 = 16384
    load_b(8'h80);
    do_run(8'h80, 1'b0, 0, 0, 0);

    // Zero multiplier
    load_b(8'h00);
    do_run(8'h5A, 1'b0, 0, 0, 0);

    // Run held in DONE, then a fresh run on the previous low byte
    load_b(8'h13);
    do_run(8'hE6, 1'b0, 0, 0, 10);
    do_run(8'h05, 1'b0, 0, 0, 0);

    // Load and Run together; ClearA_LoadB pulsed in SHF_4 (cycle 11)
    do_run(8'h02, 1'b1, 0, 11, 0);

    // Random operands
    for (int k = 0; k < 4; k++) begin
      load_b(8'($urandom_range(0, 255)));
      do_run(8'($urandom_range(0, 255)), 1'b0, 0, 0, 0);
    end

    check_val("strobe_onehot", multi_hot, 0);
    check_val("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
